// File: rtl/down_counter.sv
// ---------------------------------------------------------------------------
// down_counter
//   Loadable down-counter / timer. A load captures a start value and arms the
//   counter. Each enabled clock then decrements it, and Expire pulses for one
//   cycle on the step that reaches zero. It never wraps below zero.
//
//   Optional feature macro: DOWN_COUNTER_RELOAD_EN
//     undefined : one-shot. The counter parks in EXPIRED at zero.
//     defined   : periodic. On the expiring step it reloads the last loaded
//                 value and stays in RUN.
//
// Parameters
//   WIDTH         width of Data, Q and the reload register (default 4)
//
// Ports
//   clock         single clock, all state updates on posedge
//   reset         asynchronous, active-low clear of all state
//   Data          start value, sampled when Set_Enable=1
//   Set_Enable    synchronous load request (wins over Count_Enable)
//   Count_Enable  synchronous decrement request (honoured only in RUN)
//   Q             current count, registered
//   Busy          registered, 1 while in RUN
//   Expire        registered one-cycle pulse on the expiring decrement
//
// State     | meaning
// ----------+---------------------------------------------------------
// IDLE      | after reset, never loaded; Count_Enable ignored, Q = 0
// RUN       | armed and counting on Count_Enable
// EXPIRED   | reached zero (or loaded with zero); holds Q = 0
// ---------------------------------------------------------------------------
module down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] Data,
    input  logic             Set_Enable,
    input  logic             Count_Enable,
    output logic [WIDTH-1:0] Q,
    output logic             Busy,
    output logic             Expire
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t state;

`ifdef DOWN_COUNTER_RELOAD_EN
    logic [WIDTH-1:0] reload;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            Q      <= '0;
            Busy   <= 1'b0;
            Expire <= 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
            reload <= '0;
`endif
        end else begin
            // Expire is a pulse. It is cleared every cycle unless the
            // expiring branch below sets it again.
            Expire <= 1'b0;

            if (Set_Enable) begin
                Q <= Data;
`ifdef DOWN_COUNTER_RELOAD_EN
                reload <= Data;
`endif
                if (Data != '0) begin
                    state <= RUN;
                    Busy  <= 1'b1;
                end else begin
                    // A zero load is already expired and gives no pulse.
                    state <= EXPIRED;
                    Busy  <= 1'b0;
                end
            end else if ((state == RUN) && Count_Enable) begin
                if (Q > ONE) begin
                    Q <= Q - ONE;
                end else if (Q == ONE) begin
                    Expire <= 1'b1;
`ifdef DOWN_COUNTER_RELOAD_EN
                    Q      <= reload;
`else
                    Q      <= '0;
                    state  <= EXPIRED;
                    Busy   <= 1'b0;
`endif
                end
                // Q == 0 cannot occur in RUN. If it does, Q holds, so the
                // counter never wraps.
            end
        end
    end

endmodule

// File: tb/tb_down_counter.sv
module tb_down_counter;

    localparam int W = 4;

    logic         clock;
    logic         reset;
    logic [W-1:0] Data;
    logic         Set_Enable;
    logic         Count_Enable;
    logic [W-1:0] Q;
    logic         Busy;
    logic         Expire;

    down_counter #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .Data         (Data),
        .Set_Enable   (Set_Enable),
        .Count_Enable (Count_Enable),
        .Q            (Q),
        .Busy         (Busy),
        .Expire       (Expire)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic         rst;
        logic         set;
        logic         cnt;
        logic [W-1:0] data;
        logic [W-1:0] q;
        logic         busy;
        logic         expire;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic         busy;
        logic         expire;
        int           tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   tag_no = 0;

    function automatic void add(input logic rst, input logic set, input logic cnt,
                                input logic [W-1:0] data, input logic [W-1:0] q,
                                input logic busy, input logic expire);
        vec_t v;
        v.rst = rst; v.set = set; v.cnt = cnt; v.data = data;
        v.q = q; v.busy = busy; v.expire = expire;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int tag, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, tag, act, req);
        end
    endtask

    // Drive one cycle of stimulus on the falling edge, record the expected
    // result, then compare against the DUT just after the rising edge.
    task automatic step(input logic rst, input logic set, input logic cnt,
                        input logic [W-1:0] data, input logic [W-1:0] q,
                        input logic busy, input logic expire);
        exp_t e;
        @(negedge clock);
        reset        = rst;
        Set_Enable   = set;
        Count_Enable = cnt;
        Data         = data;
        e.q = q; e.busy = busy; e.expire = expire; e.tag = tag_no;
        sb.push_back(e);
        tag_no++;
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty step %0d: got 0 entries expected 1", tag_no);
        end else begin
            e = sb.pop_front();
            check("Q", e.tag, int'(Q), int'(e.q));
            check("Busy", e.tag, int'(Busy), int'(e.busy));
            check("Expire", e.tag, int'(Expire), int'(e.expire));
        end
    endtask

    initial begin
        int first_exp;
        logic [W-1:0] mq;
        logic mb, me;

        reset = 1'b0; Set_Enable = 1'b0; Count_Enable = 1'b0; Data = '0;

        // reset held, then IDLE ignores Count_Enable
        add(0,0,0,4'd0,  4'd0,0,0);
        add(0,1,1,4'd7,  4'd0,0,0);
        add(1,0,1,4'd0,  4'd0,0,0);
        add(1,0,1,4'd0,  4'd0,0,0);
`ifndef DOWN_COUNTER_RELOAD_EN
        // one-shot: load 6 and count 8 cycles
        add(1,1,0,4'd6,  4'd6,1,0);
        add(1,0,1,4'd0,  4'd5,1,0);
        add(1,0,1,4'd0,  4'd4,1,0);
        add(1,0,1,4'd0,  4'd3,1,0);
        add(1,0,1,4'd0,  4'd2,1,0);
        add(1,0,1,4'd0,  4'd1,1,0);
        add(1,0,1,4'd0,  4'd0,0,1);
        add(1,0,1,4'd0,  4'd0,0,0);
        add(1,0,1,4'd0,  4'd0,0,0);
`else
        // periodic: load 3 and count 9 cycles
        add(1,1,0,4'd3,  4'd3,1,0);
        add(1,0,1,4'd0,  4'd2,1,0);
        add(1,0,1,4'd0,  4'd1,1,0);
        add(1,0,1,4'd0,  4'd3,1,1);
        add(1,0,1,4'd0,  4'd2,1,0);
        add(1,0,1,4'd0,  4'd1,1,0);
        add(1,0,1,4'd0,  4'd3,1,1);
        add(1,0,1,4'd0,  4'd2,1,0);
        add(1,0,1,4'd0,  4'd1,1,0);
        add(1,0,1,4'd0,  4'd3,1,1);
`endif
        // hold and load priority
        add(1,1,0,4'd5,  4'd5,1,0);
        add(1,0,1,4'd0,  4'd4,1,0);
        add(1,0,1,4'd0,  4'd3,1,0);
        add(1,0,0,4'd0,  4'd3,1,0);
        add(1,0,0,4'd0,  4'd3,1,0);
        add(1,1,1,4'd9,  4'd9,1,0);
        add(1,0,1,4'd0,  4'd8,1,0);
        // zero load from RUN: no pulse, counting ignored afterwards
        add(1,1,1,4'd0,  4'd0,0,0);
        add(1,0,1,4'd0,  4'd0,0,0);
        add(1,0,1,4'd0,  4'd0,0,0);
        // load beats the expiring decrement at Q == 1
        add(1,1,0,4'd1,  4'd1,1,0);
        add(1,1,1,4'd2,  4'd2,1,0);
        add(1,0,1,4'd0,  4'd1,1,0);
`ifndef DOWN_COUNTER_RELOAD_EN
        add(1,0,1,4'd0,  4'd0,0,1);
        add(1,0,1,4'd0,  4'd0,0,0);
`else
        add(1,0,1,4'd0,  4'd2,1,1);
        add(1,0,1,4'd0,  4'd1,1,0);
`endif

        foreach (vecs[i])
            step(vecs[i].rst, vecs[i].set, vecs[i].cnt, vecs[i].data,
                 vecs[i].q, vecs[i].busy, vecs[i].expire);

        // asynchronous reset mid-cycle with Q = 5
        step(1,1,0,4'd5, 4'd5,1,0);
        #2 reset = 1'b0;
        #1;
        check("async_rst_Q", tag_no, int'(Q), 0);
        check("async_rst_Busy", tag_no, int'(Busy), 0);
        check("async_rst_Expire", tag_no, int'(Expire), 0);
        step(0,0,1,4'd0, 4'd0,0,0);
        step(1,0,1,4'd0, 4'd0,0,0);
        step(1,0,1,4'd0, 4'd0,0,0);

        // max load: 15 enabled decrements to expiry, no wrap afterwards
        step(1,1,0,4'hF, 4'hF,1,0);
        first_exp = 0;
        for (int i = 1; i <= 18; i++) begin
`ifndef DOWN_COUNTER_RELOAD_EN
            mq = (i < 15) ? 4'(15 - i) : 4'd0;
            mb = (i < 15);
`else
            mq = (i < 15) ? 4'(15 - i) : 4'(30 - i);
            mb = 1'b1;
`endif
            me = (i == 15);
            step(1,0,1,4'd0, mq, mb, me);
            if (Expire && first_exp == 0) first_exp = i;
        end
        check("max_load_expire_cycle", tag_no, first_exp, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no end of test expected finish");
        $fatal(1);
    end

endmodule
